// File: rtl/simon_pkg.sv
// Shared constants and the stage-record layout for the chunked pipelined adder.
// Modules import this package and size their own records from WIDTH.
package simon_pkg;

  localparam int SIMON_WIDTH = 16;
  localparam int SIMON_CHUNK = 4;

  // Record layout at the default width. Each stage declares the same layout
  // sized from its own WIDTH parameter.
  typedef struct packed {
    logic                   valid;
    logic                   carry;
    logic [SIMON_WIDTH-1:0] sum;
    logic [SIMON_WIDTH-1:0] x;
    logic [SIMON_WIDTH-1:0] y;
  } stage_rec_t;

  function automatic int num_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/simon_add_stage.sv
// One CHUNK-bit slice of the pipelined adder: adds its slice of x/y plus the
// incoming carry, and holds its record until the downstream stage can take it.
module simon_add_stage
  import simon_pkg::*;
#(
  parameter int WIDTH = SIMON_WIDTH,
  parameter int CHUNK = SIMON_CHUNK,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv_i,
  output logic             adv_o,
  input  logic             valid_i,
  input  logic             carry_i,
  input  logic [WIDTH-1:0] sum_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  output logic             valid_o,
  output logic             carry_o,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o
);

  localparam int LO = IDX * CHUNK;

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
  } rec_t;

  rec_t             rec_q;
  rec_t             rec_d;
  logic [CHUNK:0]   chunk_add;

  // An empty stage always accepts, which is what lets bubbles collapse.
  assign adv_o = !rec_q.valid || adv_i;

  always_comb begin
    chunk_add = {1'b0, x_i[LO +: CHUNK]} + {1'b0, y_i[LO +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_i};
    rec_d = rec_q;
    if (adv_o) begin
      rec_d.valid = valid_i;
      if (valid_i) begin
        rec_d.carry            = chunk_add[CHUNK];
        rec_d.sum              = sum_i;
        rec_d.sum[LO +: CHUNK] = chunk_add[CHUNK-1:0];
        rec_d.x                = x_i;
        rec_d.y                = y_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rec_q <= '0;
    end else begin
      rec_q <= rec_d;
    end
  end

  assign valid_o = rec_q.valid;
  assign carry_o = rec_q.carry;
  assign sum_o   = rec_q.sum;
  assign x_o     = rec_q.x;
  assign y_o     = rec_q.y;

endmodule

// File: rtl/simon_pipe_adder.sv
// Pipelined ripple adder: WIDTH/CHUNK registered stages with valid/ready flow
// control, back-pressure chained combinationally from out_ready to in_ready.
module simon_pipe_adder
  import simon_pkg::*;
#(
  parameter int WIDTH = SIMON_WIDTH,
  parameter int CHUNK = SIMON_CHUNK
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = num_stages(WIDTH, CHUNK);

  // Index k is the input of stage k; index STAGES is the last stage's record.
  logic [STAGES:0]            valid_a;
  logic [STAGES:0]            carry_a;
  logic [STAGES:0]            adv_a;
  logic [STAGES:0][WIDTH-1:0] sum_a;
  logic [STAGES:0][WIDTH-1:0] x_a;
  logic [STAGES:0][WIDTH-1:0] y_a;
  logic                       unused_rem;

  assign valid_a[0]     = in_valid;
  assign carry_a[0]     = cin;
  assign sum_a[0]       = '0;
  assign x_a[0]         = x;
  assign y_a[0]         = y;
  assign adv_a[STAGES]  = out_ready;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      simon_add_stage #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK),
        .IDX   (gi)
      ) u_stage (
        .clk     (clk),
        .reset   (reset),
        .adv_i   (adv_a[gi+1]),
        .adv_o   (adv_a[gi]),
        .valid_i (valid_a[gi]),
        .carry_i (carry_a[gi]),
        .sum_i   (sum_a[gi]),
        .x_i     (x_a[gi]),
        .y_i     (y_a[gi]),
        .valid_o (valid_a[gi+1]),
        .carry_o (carry_a[gi+1]),
        .sum_o   (sum_a[gi+1]),
        .x_o     (x_a[gi+1]),
        .y_o     (y_a[gi+1])
      );
    end
  endgenerate

  assign in_ready  = adv_a[0] && !reset;
  assign out_valid = valid_a[STAGES];
  assign sum       = sum_a[STAGES];
  assign cout      = carry_a[STAGES];
  // Carry into the MSB is recovered from the stored operand MSBs and sum MSB.
  assign ovf       = carry_a[STAGES] ^ sum_a[STAGES][WIDTH-1]
                   ^ x_a[STAGES][WIDTH-1] ^ y_a[STAGES][WIDTH-1];

  assign unused_rem = ^{x_a[STAGES][WIDTH-2:0], y_a[STAGES][WIDTH-2:0]};

endmodule

// File: tb/tb_simon_pipe_adder.sv
// Bench for simon_pipe_adder: fixed vectors, random streams with stalls and
// reset, checked against an arithmetic reference model; plus an 8/8 instance.
module tb_simon_pipe_adder;

  localparam int W  = 16;
  localparam int C  = 4;
  localparam int ST = W / C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [W-1:0] x, y, sum;
  logic         in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0]   x8, y8, sum8;

  simon_pipe_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  simon_pipe_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .x(x8), .y(y8), .cin(cin8), .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  int           checks = 0;
  int           passed = 0;
  int           n_out  = 0;
  res_t         q[$];
  logic         hold_valid = 1'b0;
  logic [W+2:0] hold_val;
  vec_t         tbl[7];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Reference: plain wide addition; overflow when like-signed operands give
  // a result of the other sign.
  function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b, logic ci);
    logic [W:0] full;
    res_t       r;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return r;
  endfunction

  // One clock with scoreboarding; called at a negedge with inputs driven.
  task automatic tick(output bit acc);
    res_t e;
    #1;
    check("in_ready_model", {31'd0, in_ready},
          {31'd0, (q.size() < ST) || out_ready});
    if (hold_valid) check("stall_stable", {out_valid, sum, cout, ovf}, hold_val);
    hold_valid = out_valid && !out_ready;
    hold_val   = {out_valid, sum, cout, ovf};
    if (out_valid && out_ready) begin
      n_out++;
      if (q.size() == 0) begin
        check("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        $display("out: sum=%04h cout=%0d ovf=%0d (exp %04h %0d %0d)",
                 sum, cout, ovf, e.sum, e.cout, e.ovf);
        check("stream_sum", {16'd0, sum}, {16'd0, e.sum});
        check("stream_cout", {31'd0, cout}, {31'd0, e.cout});
        check("stream_ovf", {31'd0, ovf}, {31'd0, e.ovf});
      end
    end
    acc = in_valid && in_ready;
    if (acc) q.push_back(model(x, y, cin));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_single(int idx, vec_t v);
    int lat;
    x = v.x; y = v.y; cin = v.cin; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check($sformatf("vec%0d_in_ready", idx), {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    x = W'($urandom); y = W'($urandom); cin = 1'($urandom);
    lat = 1;
    #1;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      lat++;
    end
    $display("vec%0d: x=%04h y=%04h cin=%0d -> sum=%04h cout=%0d ovf=%0d lat=%0d",
             idx, v.x, v.y, v.cin, sum, cout, ovf, lat);
    check($sformatf("vec%0d_latency", idx), lat, ST);
    check($sformatf("vec%0d_sum", idx), {16'd0, sum}, {16'd0, v.sum});
    check($sformatf("vec%0d_cout", idx), {31'd0, cout}, {31'd0, v.cout});
    check($sformatf("vec%0d_ovf", idx), {31'd0, ovf}, {31'd0, v.ovf});
    @(posedge clk);
    @(negedge clk);
    #1;
    check($sformatf("vec%0d_no_dup", idx), {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    bit acc;
    int c, sent, base;

    tbl[0] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[3] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    tbl[4] = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0};
    tbl[5] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    reset = 1'b1; in_valid = 1'b0; x = '0; y = '0; cin = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; x8 = '0; y8 = '0; cin8 = 1'b0; out_ready8 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_outputs", {13'd0, sum, cout, ovf}, 32'd0);
    check("rst_in_ready8", {31'd0, in_ready8}, 32'd0);
    check("rst_outputs8", {21'd0, out_valid8, sum8, cout8, ovf8}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_ignore_in", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_ready8", {31'd0, in_ready8}, 32'd1);
    @(negedge clk);

    for (int i = 0; i < 7; i++) apply_single(i, tbl[i]);

    // Back-to-back stream, output stalled for cycles 3..5.
    base = n_out; sent = 0; c = 0;
    x = W'($urandom); y = W'($urandom); cin = 1'($urandom);
    while ((sent < 8 || q.size() > 0) && c < 200) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 8);
      tick(acc);
      if (acc) begin
        sent++;
        x = W'($urandom); y = W'($urandom); cin = 1'($urandom);
      end
      c++;
    end
    in_valid = 1'b0;
    check("stream_count", n_out - base, 8);

    // One item stuck at the output, then three more fill the bubbles.
    base = n_out; sent = 0; c = 0;
    while ((sent < 4 || q.size() > 0) && c < 200) begin
      out_ready = (c >= 10);
      in_valid  = (sent == 0) || (sent < 4 && c >= 7);
      x = W'($urandom); y = W'($urandom); cin = 1'($urandom);
      tick(acc);
      if (in_valid && sent >= 1 && sent < 4)
        check("bubble_accept", {31'd0, acc}, 32'd1);
      if (acc) sent++;
      c++;
    end
    in_valid = 1'b0;
    check("bubble_count", n_out - base, 4);

    // Reset with three results in flight: none may survive.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      x = W'($urandom); y = W'($urandom); cin = 1'($urandom);
      tick(acc);
    end
    in_valid = 1'b0;
    tick(acc);
    tick(acc);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    q.delete();
    hold_valid = 1'b0;
    reset = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mid_rst_ready_after", {31'd0, in_ready}, 32'd1);
    base = n_out;
    repeat (6) tick(acc);
    check("no_stale_results", n_out - base, 0);
    apply_single(7, tbl[1]);

    // Single-stage configuration: latency 1.
    x8 = 8'hFF; y8 = 8'h01; cin8 = 1'b0; in_valid8 = 1'b1; out_ready8 = 1'b1;
    #1;
    check("w8_in_ready", {31'd0, in_ready8}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    x8 = 8'h7F; y8 = 8'h01;
    #1;
    $display("w8: FF+01 -> valid=%0d sum=%02h cout=%0d ovf=%0d", out_valid8, sum8, cout8, ovf8);
    check("w8_valid", {31'd0, out_valid8}, 32'd1);
    check("w8_sum", {24'd0, sum8}, 32'h00);
    check("w8_cout", {31'd0, cout8}, 32'd1);
    check("w8_ovf", {31'd0, ovf8}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    #1;
    $display("w8: 7F+01 -> valid=%0d sum=%02h cout=%0d ovf=%0d", out_valid8, sum8, cout8, ovf8);
    check("w8b_sum", {24'd0, sum8}, 32'h80);
    check("w8b_cout_ovf", {30'd0, cout8, ovf8}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("w8_drained", {31'd0, out_valid8}, 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
